// File: rtl/register_file_pkg.sv
// Shared datapath types and constants for the general-purpose register file.
package register_file_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback-side bundle for the register file: two read ports, one write port.
interface register_file_if
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
);

    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic              we3;
    logic [DATA_W-1:0] wd3;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    modport master (
        output a1, a2, a3, we3, wd3,
        input  rd1, rd2
    );

    modport slave (
        input  a1, a2, a3, we3, wd3,
        output rd1, rd2
    );

endinterface

// File: rtl/register_file.sv
// 2**ADDR_W x DATA_W register file: two combinational read ports, one clocked write port,
// x0 hardwired to zero, asynchronous active-low clear.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NumRegs];

    // Entry 0 is cleared on reset and never written; the read path also forces it to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else if (bus.we3 && (bus.a3 != ZeroAddr)) begin
            regs_q[bus.a3] <= bus.wd3;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        return (addr == ZeroAddr) ? '0 : regs_q[addr];
    endfunction

    // No write-to-read bypass: a same-cycle write becomes visible only after the edge.
    always_comb begin
        bus.rd1 = read_port(bus.a1);
        bus.rd2 = read_port(bus.a2);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.a3  = addr;
        bus.wd3 = data;
        bus.we3 = 1'b1;
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
    endtask

    task automatic read_both(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.a1 = addr;
        bus.a2 = addr;
        #1;
        check({tag, "_rd1"}, bus.rd1, exp);
        check({tag, "_rd2"}, bus.rd2, exp);
    endtask

    initial begin
        rst_n   = 1'b1;
        bus.a1  = '0;
        bus.a2  = '0;
        bus.a3  = '0;
        bus.we3 = 1'b0;
        bus.wd3 = '0;
        #2 rst_n = 1'b0;
        #1;

        // Reads during reset
        bus.a1 = 5'd5;
        bus.a2 = 5'd31;
        #1;
        check("reset_rd1", bus.rd1, 32'h0);
        check("reset_rd2", bus.rd2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read
        write_reg(5'd4, 32'd5);
        bus.a1 = 5'd4;
        #1;
        check("basic_rd1", bus.rd1, 32'd5);
        bus.a2 = 5'd4;
        #1;
        check("basic_rd2", bus.rd2, 32'd5);
        bus.a2 = 5'd0;
        #1;
        check("basic_rd2_x0", bus.rd2, 32'd0);

        // Write to x0 is discarded
        write_reg(5'd0, 32'hDEADBEEF);
        bus.a1 = 5'd0;
        #1;
        check("x0_write", bus.rd1, 32'd0);

        // Write disabled
        write_reg(5'd7, 32'h1234);
        @(negedge clk);
        bus.a3  = 5'd7;
        bus.wd3 = 32'hFFFF_FFFF;
        bus.we3 = 1'b0;
        @(posedge clk);
        #1;
        bus.a1 = 5'd7;
        #1;
        check("we_off", bus.rd1, 32'h1234);

        // Idempotent / last write wins
        write_reg(5'd9, 32'hAAAA_5555);
        write_reg(5'd9, 32'hAAAA_5555);
        read_both("idem", 5'd9, 32'hAAAA_5555);
        write_reg(5'd9, 32'h0BAD_F00D);
        read_both("last_wins", 5'd9, 32'h0BAD_F00D);

        // Dual-port independence and read-during-write
        write_reg(5'd1, 32'd11);
        write_reg(5'd31, 32'd99);
        bus.a1 = 5'd1;
        bus.a2 = 5'd31;
        #1;
        check("dual_rd1", bus.rd1, 32'd11);
        check("dual_rd2", bus.rd2, 32'd99);
        @(negedge clk);
        bus.a3  = 5'd1;
        bus.wd3 = 32'd22;
        bus.we3 = 1'b1;
        #1;
        check("rdw_before", bus.rd1, 32'd11);
        @(posedge clk);
        #1;
        bus.we3 = 1'b0;
        check("rdw_after", bus.rd1, 32'd22);
        check("rdw_other", bus.rd2, 32'd99);

        // Asynchronous reset between edges
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        read_both("prefill_r17", 5'd17, 32'd17);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) read_both($sformatf("async_rst[%0d]", i), 5'(i), 32'd0);
        write_reg(5'd9, 32'hCAFE_0001);
        read_both("write_in_rst", 5'd9, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        write_reg(5'd4, 32'd5);
        read_both("post_rst_wr", 5'd4, 32'd5);
        read_both("post_rst_r9", 5'd9, 32'd0);

        // Exhaustive sweep
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            read_both($sformatf("sweep[%0d]", i), 5'(i), 32'(i) * 32'h0101_0101);
        end

        // Distinct addresses on both ports in one cycle
        bus.a1 = 5'd3;
        bus.a2 = 5'd30;
        #1;
        check("sweep_pair_rd1", bus.rd1, 32'h0303_0303);
        check("sweep_pair_rd2", bus.rd2, 32'h1E1E_1E1E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry × 32-bit general-purpose register file for a single-cycle RISC-V style datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between instruction decode (addresses) and the ALU/writeback path (data).

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width; number of registers is 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a1  in  ADDR_W  read address, port 1.
- a2  in  ADDR_W  read address, port 2.
- a3  in  ADDR_W  write address.
- we3  in  1  write enable; active high.
- wd3  in  DATA_W  write data.
- rd1  out  DATA_W  read data, port 1.
- rd2  out  DATA_W  read data, port 2.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Index 0 is not stored, or is always forced to 0.
- Reset:
  - rst_n low clears every register to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, rd1 and rd2 read 0 for any address.
  - Writes are ignored while rst_n is low.
  - Deassertion is taken synchronously to the next clk rising edge.
- Write:
  - On a rising edge of clk with rst_n high and we3 = 1, reg[a3] <= wd3.
  - If a3 == 0 the write is discarded.
  - we3 = 0 means no register changes.
- Read:
  - rd1 = (a1 == 0) ? 0 : reg[a1], and rd2 likewise from a2.
  - Both reads are purely combinational with zero latency.
  - A read reflects an address change within the same cycle.
- Read-during-write to the same address in the same cycle:
  - Before the edge, rd returns the old value.
  - After the edge, rd returns the new value.
  - No internal bypass/forwarding; the pipeline handles hazards.
- a1 == a2 is legal; both ports return identical data.
- Writing the same value repeatedly is idempotent; the last write wins.
- No X propagation from storage after reset: all reads are defined.
- Reset asserted mid-operation, including coincident with a write edge:
  - Reset dominates; the write is lost.
  - All registers read 0.

Decomposition:
- Shared package (e.g. riscv_pkg):
  - XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32.
  - Constant ZERO_REG = 5'd0.
  - typedef word_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_ADDR_W-1:0]).
- No sub-module is required; a single flat module is natural.
- Optional: factor the read mux with zero-forcing into one function used by both ports.

Test Plan:
- Basic write/read:
  - rst_n = 1, a3 = 4, wd3 = 5, we3 = 1, one rising edge.
  - Set a1 = 4 → rd1 = 5.
  - Set a2 = 4 → rd2 = 5.
  - a2 = 0 → rd2 = 0.
- Write to x0:
  - a3 = 0, wd3 = 32'hDEADBEEF, we3 = 1, one edge.
  - a1 = 0 → rd1 = 0.
- Write disabled:
  - Preload r7 = 32'h1234, then a3 = 7, wd3 = 32'hFFFF_FFFF, we3 = 0, one edge.
  - rd1 (a1 = 7) = 32'h1234.
- Dual-port independence and read-during-write:
  - Preload r1 = 11 and r31 = 99; a1 = 1, a2 = 31 → rd1 = 11, rd2 = 99.
  - Then a3 = 1, wd3 = 22, we3 = 1: rd1 = 11 before the edge and 22 after it; rd2 stays 99.
- Asynchronous reset:
  - Fill r1..r31 with their index values.
  - Pull rst_n low between clock edges → every address reads 0 immediately, with no clock edge.
  - A write attempted while rst_n is low has no effect.
  - After release, a write of 5 to r4 succeeds.
- Exhaustive sweep:
  - Write value (i * 32'h01010101) to each i = 1..31, then read all addresses on both ports.
  - All values must match, and address 0 must read 0.
